// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multicycle RV32I-subset control unit.
// ILLEGAL_TRAP_EN adds the S_TRAP state for unrecognised opcodes.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BEQ    = 4'd9,
    S_JAL    = 4'd10
`ifdef ILLEGAL_TRAP_EN
    , S_TRAP = 4'd11
`endif
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'd0,
    ALUOP_SUB   = 2'd1,
    ALUOP_FUNCT = 2'd2
  } alu_op_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_BAD = 4'b1111;

  // State following S_DECODE for a given opcode.
  function automatic state_t decode_next(input logic [6:0] op);
    state_t nxt;
    case (op)
      OP_LW, OP_SW: nxt = S_MEMADR;
      OP_R:         nxt = S_EXECR;
      OP_I:         nxt = S_EXECI;
      OP_BEQ:       nxt = S_BEQ;
      OP_JAL:       nxt = S_JAL;
`ifdef ILLEGAL_TRAP_EN
      default:      nxt = S_TRAP;
`else
      default:      nxt = S_FETCH;
`endif
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// Combinational ALU control decode from the per-state ALU op and funct fields.
// Unaffected by ILLEGAL_TRAP_EN.
module alu_decoder
  import ctrl_pkg::*;
(
  input  alu_op_t     i_alu_op,
  input  logic [2:0]  i_funct3,
  input  logic        i_op5,
  input  logic        i_funct7b5,
  output logic [3:0]  o_alu_ctrl
);

  always_comb begin
    o_alu_ctrl = ALU_ADD;
    unique case (i_alu_op)
      ALUOP_ADD: o_alu_ctrl = ALU_ADD;
      ALUOP_SUB: o_alu_ctrl = ALU_SUB;
      ALUOP_FUNCT: begin
        unique case (i_funct3)
          // op5 distinguishes R-type from I-type, so addi never subtracts.
          3'b000:  o_alu_ctrl = (i_op5 && i_funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  o_alu_ctrl = ALU_SLT;
          3'b110:  o_alu_ctrl = ALU_OR;
          3'b111:  o_alu_ctrl = ALU_AND;
          default: o_alu_ctrl = ALU_BAD;
        endcase
      end
      default: o_alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I-subset control FSM with Moore datapath controls.
// Define ILLEGAL_TRAP_EN to trap unrecognised opcodes in S_TRAP with sticky o_illegal.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter state_t RESET_STATE = S_FETCH
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [6:0]  i_op,
  input  logic [2:0]  i_funct3,
  input  logic        i_funct7b5,
  input  logic        i_zero,
  input  logic        i_mem_ready,
  output logic        o_pc_write,
  output logic        o_adr_src,
  output logic        o_mem_write,
  output logic        o_ir_write,
  output logic        o_reg_write,
  output logic [1:0]  o_result_src,
  output logic [1:0]  o_alu_src_a,
  output logic [1:0]  o_alu_src_b,
  output logic [3:0]  o_alu_ctrl,
  output logic [3:0]  o_state,
  output logic        o_illegal
);

  state_t  r_state;
  alu_op_t w_alu_op;
  logic    w_pc_write;
  logic    w_mem_write;
  logic    w_ir_write;
  logic    w_reg_write;

`ifdef ILLEGAL_TRAP_EN
  logic r_illegal;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= RESET_STATE;
`ifdef ILLEGAL_TRAP_EN
      r_illegal <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_FETCH:  if (i_mem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          r_state <= decode_next(i_op);
`ifdef ILLEGAL_TRAP_EN
          // Set on the transition so the flag is visible in the first S_TRAP cycle.
          if (decode_next(i_op) == S_TRAP) r_illegal <= 1'b1;
`endif
        end
        S_MEMADR: r_state <= i_op[5] ? S_MEMWR : S_MEMRD;
        S_MEMRD:  if (i_mem_ready) r_state <= S_MEMWB;
        S_MEMWB:  r_state <= S_FETCH;
        S_MEMWR:  if (i_mem_ready) r_state <= S_FETCH;
        S_EXECR:  r_state <= S_ALUWB;
        S_EXECI:  r_state <= S_ALUWB;
        S_ALUWB:  r_state <= S_FETCH;
        S_BEQ:    r_state <= S_FETCH;
        S_JAL:    r_state <= S_ALUWB;
`ifdef ILLEGAL_TRAP_EN
        S_TRAP:   r_state <= S_TRAP;
`endif
        default:  r_state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    w_pc_write   = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_reg_write  = 1'b0;
    o_adr_src    = 1'b0;
    o_result_src = 2'b00;
    o_alu_src_a  = 2'b00;
    o_alu_src_b  = 2'b00;
    w_alu_op     = ALUOP_ADD;
    case (r_state)
      S_FETCH: begin
        o_alu_src_b  = 2'b10;
        o_result_src = 2'b10;
        w_ir_write   = i_mem_ready;
        w_pc_write   = i_mem_ready;
      end
      S_DECODE: begin
        o_alu_src_a = 2'b01;
        o_alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        o_alu_src_a = 2'b10;
        o_alu_src_b = 2'b01;
      end
      S_MEMRD:  o_adr_src = 1'b1;
      S_MEMWB: begin
        o_result_src = 2'b01;
        w_reg_write  = 1'b1;
      end
      S_MEMWR: begin
        o_adr_src   = 1'b1;
        w_mem_write = 1'b1;
      end
      S_EXECR: begin
        o_alu_src_a = 2'b10;
        w_alu_op    = ALUOP_FUNCT;
      end
      S_EXECI: begin
        o_alu_src_a = 2'b10;
        o_alu_src_b = 2'b01;
        w_alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB:  w_reg_write = 1'b1;
      S_BEQ: begin
        o_alu_src_a = 2'b10;
        w_alu_op    = ALUOP_SUB;
        w_pc_write  = i_zero;
      end
      S_JAL: begin
        o_alu_src_a = 2'b01;
        o_alu_src_b = 2'b10;
        w_pc_write  = 1'b1;
      end
      default: ;
    endcase
  end

  alu_decoder u_alu_decoder (
    .i_alu_op   (w_alu_op),
    .i_funct3   (i_funct3),
    .i_op5      (i_op[5]),
    .i_funct7b5 (i_funct7b5),
    .o_alu_ctrl (o_alu_ctrl)
  );

  // Enables are suppressed during reset so an abandoned instruction has no side effects.
  assign o_pc_write  = w_pc_write  & ~i_rst;
  assign o_mem_write = w_mem_write & ~i_rst;
  assign o_ir_write  = w_ir_write  & ~i_rst;
  assign o_reg_write = w_reg_write & ~i_rst;
  assign o_state     = r_state;

`ifdef ILLEGAL_TRAP_EN
  assign o_illegal = r_illegal;
`else
  assign o_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed cases then random instruction streams
// checked cycle by cycle against a per-instruction expected trace.
module tb_multicycle_ctrl;
  import ctrl_pkg::*;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BEQ = 7'b1100011;
  localparam logic [6:0] JAL = 7'b1101111;
  localparam int DC = -1;

  logic       i_clk = 1'b0;
  logic       i_rst, i_funct7b5, i_zero, i_mem_ready;
  logic [6:0] i_op;
  logic [2:0] i_funct3;
  logic       o_pc_write, o_adr_src, o_mem_write, o_ir_write, o_reg_write, o_illegal;
  logic [1:0] o_result_src, o_alu_src_a, o_alu_src_b;
  logic [3:0] o_alu_ctrl, o_state;

  always #5 i_clk = ~i_clk;

  multicycle_ctrl #(.RESET_STATE(S_FETCH)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_op(i_op), .i_funct3(i_funct3),
    .i_funct7b5(i_funct7b5), .i_zero(i_zero), .i_mem_ready(i_mem_ready),
    .o_pc_write(o_pc_write), .o_adr_src(o_adr_src), .o_mem_write(o_mem_write),
    .o_ir_write(o_ir_write), .o_reg_write(o_reg_write), .o_result_src(o_result_src),
    .o_alu_src_a(o_alu_src_a), .o_alu_src_b(o_alu_src_b), .o_alu_ctrl(o_alu_ctrl),
    .o_state(o_state), .o_illegal(o_illegal)
  );

  // One expected cycle: inputs to drive, plus expected outputs with a care mask.
  typedef struct {
    logic        rst, rdy, zero, f7;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [19:0] exp, msk;
  } cyc_t;

  cyc_t q[$];
  int unsigned n_run = 0, n_fail = 0;
  logic [6:0] g_op;
  logic [2:0] g_f3;
  logic       g_f7, g_zero, g_rst;
  int         g_ill;

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic int exp_alu(bit op5, bit [2:0] f3, bit f7);
    if (f3 == 3'b000) return (op5 && f7) ? 6 : 2;
    if (f3 == 3'b010) return 7;
    if (f3 == 3'b110) return 1;
    if (f3 == 3'b111) return 0;
    return 15;
  endfunction

  task automatic push(state_t st, bit rdy, int pcw, int adr, int mw, int irw, int rw,
                      int res, int sa, int sb, int alu);
    cyc_t c;
    c.rst = g_rst; c.rdy = rdy; c.zero = g_zero; c.op = g_op; c.f3 = g_f3; c.f7 = g_f7;
    c.exp = '0; c.msk = '0;
    if (g_ill >= 0) begin c.exp[19] = g_ill[0]; c.msk[19] = 1'b1; end
    c.exp[18:15] = st;     c.msk[18:15] = '1;
    c.exp[14] = pcw[0];    c.msk[14] = 1'b1;
    if (adr >= 0) begin c.exp[13] = adr[0]; c.msk[13] = 1'b1; end
    c.exp[12] = mw[0];     c.msk[12] = 1'b1;
    c.exp[11] = irw[0];    c.msk[11] = 1'b1;
    c.exp[10] = rw[0];     c.msk[10] = 1'b1;
    if (res >= 0) begin c.exp[9:8] = res[1:0]; c.msk[9:8] = '1; end
    if (sa >= 0)  begin c.exp[7:6] = sa[1:0];  c.msk[7:6] = '1; end
    if (sb >= 0)  begin c.exp[5:4] = sb[1:0];  c.msk[5:4] = '1; end
    if (alu >= 0) begin c.exp[3:0] = alu[3:0]; c.msk[3:0] = '1; end
    q.push_back(c);
  endtask

  task automatic push_rst(state_t st);
    g_rst = 1'b1;
    push(st, 1'b1, 0, DC, 0, 0, 0, DC, DC, DC, DC);
    g_rst = 1'b0;
  endtask

  // Expected trace of one instruction with sf fetch stalls and sm memory stalls.
  task automatic build(logic [6:0] op, logic [2:0] f3, logic f7, logic zero, int sf, int sm);
    g_op = op; g_f3 = f3; g_f7 = f7; g_zero = zero; g_rst = 1'b0; g_ill = 0;
    for (int k = 0; k < sf; k++) push(S_FETCH, 1'b0, 0, 0, 0, 0, 0, 2, 0, 2, 2);
    push(S_FETCH, 1'b1, 1, 0, 0, 1, 0, 2, 0, 2, 2);
    push(S_DECODE, rb(), 0, DC, 0, 0, 0, DC, 1, 1, 2);
    case (op)
      LW: begin
        push(S_MEMADR, rb(), 0, DC, 0, 0, 0, DC, 2, 1, 2);
        for (int k = 0; k < sm; k++) push(S_MEMRD, 1'b0, 0, 1, 0, 0, 0, 0, DC, DC, DC);
        push(S_MEMRD, 1'b1, 0, 1, 0, 0, 0, 0, DC, DC, DC);
        push(S_MEMWB, rb(), 0, DC, 0, 0, 1, 1, DC, DC, DC);
      end
      SW: begin
        push(S_MEMADR, rb(), 0, DC, 0, 0, 0, DC, 2, 1, 2);
        for (int k = 0; k < sm; k++) push(S_MEMWR, 1'b0, 0, 1, 1, 0, 0, 0, DC, DC, DC);
        push(S_MEMWR, 1'b1, 0, 1, 1, 0, 0, 0, DC, DC, DC);
      end
      RT, IT: begin
        push((op == RT) ? S_EXECR : S_EXECI, rb(), 0, DC, 0, 0, 0, DC, 2,
             (op == RT) ? 0 : 1, exp_alu(op[5], f3, f7));
        push(S_ALUWB, rb(), 0, DC, 0, 0, 1, 0, DC, DC, DC);
      end
      BEQ: push(S_BEQ, rb(), int'(zero), DC, 0, 0, 0, 0, 2, 0, 6);
      JAL: begin
        push(S_JAL, rb(), 1, DC, 0, 0, 0, 0, 1, 2, 2);
        push(S_ALUWB, rb(), 0, DC, 0, 0, 1, 0, DC, DC, DC);
      end
      default: begin
`ifdef ILLEGAL_TRAP_EN
        g_ill = 1;
        for (int k = 0; k < 3; k++) push(S_TRAP, rb(), 0, DC, 0, 0, 0, DC, DC, DC, DC);
        g_ill = DC;
        push_rst(S_TRAP);
        g_ill = 0;
`endif
      end
    endcase
  endtask

  task automatic run_q();
    while (q.size() > 0) begin
      cyc_t c;
      logic [19:0] obs;
      c = q.pop_front();
      i_rst = c.rst; i_mem_ready = c.rdy; i_zero = c.zero;
      i_op = c.op; i_funct3 = c.f3; i_funct7b5 = c.f7;
      #1;
      obs = {o_illegal, o_state, o_pc_write, o_adr_src, o_mem_write, o_ir_write,
             o_reg_write, o_result_src, o_alu_src_a, o_alu_src_b, o_alu_ctrl};
      n_run++;
      assert ((obs & c.msk) === c.exp) else begin
        n_fail++;
        $error("FAIL step%0d op=%b state=%0d observed=%h expected=%h mask=%h",
               n_run, c.op, o_state, obs & c.msk, c.exp, c.msk);
      end
      @(posedge i_clk);
      #1;
    end
  endtask

  initial begin
    logic [6:0] ill_ops [4];
    ill_ops[0] = 7'b1111111; ill_ops[1] = 7'b0110111;
    ill_ops[2] = 7'b0010111; ill_ops[3] = 7'b1100111;
    i_rst = 1'b1; i_mem_ready = 1'b1; i_zero = 1'b0;
    i_op = '0; i_funct3 = '0; i_funct7b5 = 1'b0;
    g_op = '0; g_f3 = '0; g_f7 = 1'b0; g_zero = 1'b0; g_rst = 1'b0; g_ill = 0;
    @(posedge i_clk);
    #1;
    push_rst(S_FETCH);
    push_rst(S_FETCH);
    run_q();

    build(LW,  3'b010, 1'b0, 1'b0, 0, 0); run_q();
    build(SW,  3'b010, 1'b0, 1'b0, 0, 3); run_q();
    build(RT,  3'b000, 1'b1, 1'b0, 0, 0); run_q();
    build(IT,  3'b000, 1'b1, 1'b0, 0, 0); run_q();
    build(IT,  3'b010, 1'b0, 1'b0, 0, 0); run_q();
    build(RT,  3'b101, 1'b0, 1'b0, 1, 0); run_q();
    build(BEQ, 3'b000, 1'b0, 1'b1, 0, 0); run_q();
    build(BEQ, 3'b000, 1'b0, 1'b0, 0, 0); run_q();
    build(JAL, 3'b000, 1'b0, 1'b0, 2, 0); run_q();
    build(7'b1111111, 3'b000, 1'b0, 1'b0, 0, 0); run_q();
    build(LW,  3'b010, 1'b0, 1'b0, 1, 2); run_q();

    // Reset in the middle of a stalled store abandons it with no write strobe.
    build(SW, 3'b010, 1'b0, 1'b0, 0, 2);
    void'(q.pop_back());
    void'(q.pop_back());
    g_ill = 0;
    push_rst(S_MEMWR);
    run_q();

    for (int n = 0; n < 150; n++) begin
      logic [6:0] op;
      case ($urandom_range(0, 6))
        0: op = LW;
        1: op = SW;
        2: op = RT;
        3: op = IT;
        4: op = BEQ;
        5: op = JAL;
        default: op = ill_ops[$urandom_range(0, 3)];
      endcase
      build(op, 3'($urandom_range(0, 7)), rb(), rb(),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      run_q();
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Control unit for the multicycle RV32I-subset processor. It sequences each instruction through fetch, decode, execute, memory and writeback states. It drives the datapath enables and mux selects, and produces the 4-bit ALU control code consumed by the existing ALU. It sits between the instruction register, the memory interface and the ALU.

Parameters:
- RESET_STATE, S_FETCH: state entered on reset.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous reset, active-high
- i_op  in  7  instruction opcode, bits [6:0]
- i_funct3  in  3  instruction bits [14:12]
- i_funct7b5  in  1  instruction bit 30
- i_zero  in  1  ALU zero flag
- i_mem_ready  in  1  memory completes the current access this cycle
- o_pc_write  out  1  PC update enable
- o_adr_src  out  1  memory address select: 0=PC, 1=ALUOut
- o_mem_write  out  1  memory write strobe
- o_ir_write  out  1  instruction register load
- o_reg_write  out  1  register file write
- o_result_src  out  2  result select: 00=ALUOut, 01=ReadData, 10=ALUResult
- o_alu_src_a  out  2  ALU A select: 00=PC, 01=OldPC, 10=rs1
- o_alu_src_b  out  2  ALU B select: 00=rs2, 01=Imm, 10=const 4
- o_alu_ctrl  out  4  ALU operation: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111
- o_state  out  4  current state, for debug
- o_illegal  out  1  sticky illegal-opcode flag (optional feature only)

Behaviour:
- Reset: synchronous, active-high. While i_rst=1:
  - next state is S_FETCH;
  - o_pc_write, o_mem_write, o_ir_write and o_reg_write are forced to 0;
  - o_illegal clears to 0.
- Outputs are Moore: combinational from the registered state, except the qualifiers noted below.
- S_FETCH: adr_src=0, src_a=00, src_b=10, ADD, result_src=10.
  - i_mem_ready=1: ir_write=1, pc_write=1, go to S_DECODE.
  - i_mem_ready=0: ir_write=0, pc_write=0, stay in S_FETCH.
- S_DECODE: src_a=01, src_b=01, ADD (branch target lands in ALUOut). Next state by opcode:
  - 0000011 or 0100011 -> S_MEMADR
  - 0110011 -> S_EXECR
  - 0010011 -> S_EXECI
  - 1100011 -> S_BEQ
  - 1101111 -> S_JAL
  - any other opcode -> S_FETCH (see Optional Feature)
- S_MEMADR: src_a=10, src_b=01, ADD. Next is S_MEMRD if i_op[5]=0, else S_MEMWR.
- S_MEMRD: adr_src=1, result_src=00. Wait for i_mem_ready, then go to S_MEMWB.
- S_MEMWB: result_src=01, reg_write=1, then S_FETCH.
- S_MEMWR: adr_src=1, result_src=00, mem_write=1 held until i_mem_ready=1, then S_FETCH.
- S_EXECR: src_a=10, src_b=00, funct decode, then S_ALUWB.
- S_EXECI: src_a=10, src_b=01, funct decode, then S_ALUWB.
- S_ALUWB: result_src=00, reg_write=1, then S_FETCH.
- S_BEQ: src_a=10, src_b=00, SUB, result_src=00, pc_write=i_zero, then S_FETCH.
- S_JAL: src_a=01, src_b=10, ADD, result_src=00, pc_write=1, then S_ALUWB (link register = PC+4).
- Funct decode:
  - funct3 000: SUB when i_op[5]=1 and i_funct7b5=1, otherwise ADD. I-type addi therefore never subtracts.
  - funct3 010 -> SLT; 110 -> OR; 111 -> AND.
  - any other funct3 -> 4'b1111, the ALU's default code.
- Latency in cycles:
  - lw 5, sw 4, R-type and I-type 4, beq 3, jal 4;
  - plus one cycle for each cycle i_mem_ready is low in S_FETCH, S_MEMRD or S_MEMWR.
- Reset asserted mid-instruction: the instruction is abandoned and no enable fires in that cycle.
- If i_mem_ready is already high on entry to a memory state, that state lasts one cycle.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined:
  - an unrecognised opcode in S_DECODE moves to S_TRAP;
  - S_TRAP sets o_illegal=1, drives all enables to 0 and holds until i_rst;
  - o_illegal is sticky.
- Undefined:
  - an unrecognised opcode returns to S_FETCH, behaving as a NOP because PC was already advanced in S_FETCH;
  - o_illegal is tied to 0 and S_TRAP does not exist.

Decomposition:
- Package ctrl_pkg holds:
  - state_t enum (4-bit);
  - opcode localparams: OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL;
  - ALU code localparams: ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_BAD;
  - alu_op_t enum: ADD / SUB / FUNCT.
- One sub-module, alu_decoder (combinational). Inputs: alu_op, funct3, op5, funct7b5. Output: alu_ctrl. multicycle_ctrl supplies alu_op per state.

Test Plan:
- Reset: i_rst=1 for 2 cycles with i_mem_ready=1 -> o_state=S_FETCH, all enables 0; after release, first cycle shows ir_write=1, pc_write=1.
- lw (op 0000011), ready always 1 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; reg_write only in cycle 5 with result_src=01.
- sw with i_mem_ready low 3 cycles in S_MEMWR -> mem_write stays 1 for 4 cycles; return to FETCH on the cycle after ready.
- R-type funct3=000, funct7b5=1 -> o_alu_ctrl=0110 in S_EXECR. I-type funct3=000, funct7b5=1 -> 0010. funct3=010 -> 0111.
- beq with i_zero=1 -> pc_write=1 in S_BEQ with alu_ctrl=0110; i_zero=0 -> pc_write=0.
- Opcode 1111111 -> with ILLEGAL_TRAP_EN: S_TRAP, o_illegal=1 until reset. Without it: back to S_FETCH next cycle, o_illegal=0.
